// File: rtl/vector_alu_seq.sv
// Multi-lane integer execute unit: ADD/SUB/AND/OR/XOR in one step, MUL by
// iterative shift-add over WIDTH cycles, with a start/busy/done handshake.
module vector_alu_seq #(
    parameter int WIDTH = 32,
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [7:0]             opcode,
    input  logic [LANES*WIDTH-1:0] a,
    input  logic [LANES*WIDTH-1:0] b,
    output logic [LANES*WIDTH-1:0] result,
    output logic                   done,
    output logic                   busy,
    output logic                   err
);
    localparam int VW = LANES * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [7:0] OP_ADD = 8'h01;
    localparam logic [7:0] OP_MUL = 8'h02;
    localparam logic [7:0] OP_SUB = 8'h03;
    localparam logic [7:0] OP_AND = 8'h04;
    localparam logic [7:0] OP_OR  = 8'h05;
    localparam logic [7:0] OP_XOR = 8'h06;

    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

    state_t          state, state_next;
    logic [7:0]      op_q;
    logic [VW-1:0]   a_q, b_q;
    logic [VW-1:0]   acc, acc_next;
    logic [VW-1:0]   exec_val;
    logic [CW-1:0]   count;
    logic            op_legal;
    logic            mul_last;

    assign op_legal = (op_q >= OP_ADD) && (op_q <= OP_XOR);
    assign mul_last = (count == CW'(WIDTH - 1));

    always_comb begin
        logic [WIDTH-1:0] la, lb;
        exec_val = '0;
        acc_next = acc;
        la       = '0;
        lb       = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            la = a_q[i*WIDTH +: WIDTH];
            lb = b_q[i*WIDTH +: WIDTH];
            case (op_q)
                OP_ADD:  exec_val[i*WIDTH +: WIDTH] = la + lb;
                OP_SUB:  exec_val[i*WIDTH +: WIDTH] = la - lb;
                OP_AND:  exec_val[i*WIDTH +: WIDTH] = la & lb;
                OP_OR:   exec_val[i*WIDTH +: WIDTH] = la | lb;
                OP_XOR:  exec_val[i*WIDTH +: WIDTH] = la ^ lb;
                default: exec_val[i*WIDTH +: WIDTH] = '0;
            endcase
            // One shift-add step per lane: b is the multiplier, a the multiplicand.
            if (lb[count]) begin
                acc_next[i*WIDTH +: WIDTH] = acc[i*WIDTH +: WIDTH] + (la << count);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (opcode == OP_MUL) ? MUL : EXEC;
            EXEC:    state_next = DONE;
            MUL:     if (mul_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            acc    <= '0;
            count  <= '0;
            result <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state <= state_next;
            done  <= (state_next == DONE);
            busy  <= (state_next != IDLE);
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q  <= opcode;
                        a_q   <= a;
                        b_q   <= b;
                        acc   <= '0;
                        count <= '0;
                    end
                end
                EXEC: begin
                    result <= exec_val;
                    err    <= !op_legal;
                end
                MUL: begin
                    acc   <= acc_next;
                    count <= count + CW'(1);
                    if (mul_last) result <= acc_next;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/vector_alu_seq.md
Name: vector_alu_seq

Overview:
- Parametrised, multi-lane integer execute unit for the CPU datapath.
- Successor to the single-lane, always-done ADD/MULT unit, with these additions:
  - start/busy/done handshake
  - LANES independent lanes of WIDTH bits
  - wider opcode set
  - iterative shift-add multiplier in place of a combinational multiply
- Sits between the decode stage (opcode and operand source) and writeback (result sink).

Parameters:
- WIDTH, 32, bits per lane.
- LANES, 4, number of parallel lanes; total vector width is LANES*WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only while busy=0.
- opcode  input  8  operation; latched with start.
- a  input  LANES*WIDTH  operand A; lane i is bits [i*WIDTH +: WIDTH].
- b  input  LANES*WIDTH  operand B; same lane packing as a.
- result  output  LANES*WIDTH  lane-packed result; held until the next done.
- done  output  1  one-cycle pulse when result is valid.
- busy  output  1  high from the cycle after start is accepted through the done cycle.
- err  output  1  pulses with done when the opcode was illegal.

Behaviour:
- Reset:
  - When rst=1 at a clk edge: state=IDLE, result=0, done=0, busy=0, err=0, internal counters and operand registers cleared.
  - Reset mid-operation aborts the operation; no done is produced for it.
- Opcodes, lane-wise, unsigned, modulo 2^WIDTH, no carry or borrow between lanes:
  - 8'h01 ADD: a+b.
  - 8'h02 MUL: low WIDTH bits of a*b.
  - 8'h03 SUB: a-b.
  - 8'h04 AND.
  - 8'h05 OR.
  - 8'h06 XOR.
  - Any other value is illegal.
- States: IDLE, EXEC, MUL, DONE.
  - IDLE: busy=0. On start=1, latch opcode, a and b. MUL goes to state MUL with count=0; every other opcode goes to EXEC.
  - EXEC: busy=1. Compute the lane results and register them into result.
    - Illegal opcode: result=0, err=1 on the done cycle.
    - Go to DONE.
  - MUL: busy=1. Each cycle, every lane in parallel performs one step:
    - if multiplier bit[count]=1, acc += multiplicand << count, truncated to WIDTH;
    - count increments.
    - After the step with count=WIDTH-1, go to DONE with result=acc.
    - Takes exactly WIDTH cycles in MUL.
  - DONE: done=1, busy=1 for this single cycle; err=1 only for an illegal opcode. Next state is IDLE.
- Latency, with start accepted at edge E0:
  - Non-MUL ops: done is high in the cycle after edge E0+2, i.e. 2 edges.
  - MUL: done after E0+WIDTH+1 edges.
  - Throughput is one operation per latency+1 cycles, because the return to IDLE costs one cycle.
- Handshake rules:
  - start while busy=1 is ignored; the request is not queued.
  - start in the same cycle DONE exits is ignored; it is accepted only once state is IDLE.
- Stability rules:
  - a, b and opcode may change after acceptance without effect, because the operands are latched.
  - result changes only on the edge that enters DONE, or on reset.
- done, busy and err are registered outputs.
- Simultaneous rst and start: reset wins.

Test Plan:
- Reset then idle: assert rst for 2 cycles with start=1 -> result=0, done=0, busy=0, err=0; no operation starts.
- ADD with lane wrap, WIDTH=32, LANES=4, lane0 first:
  - Stimulus: a={FFFFFFFF,1,7,80000000}, b={1,2,3,80000000}, opcode=01.
  - Required: result={0,3,A,0}, done pulses once at 2 edges after acceptance, err=0, no carry into lane1.
- SUB and logic ops:
  - Stimulus: a lanes={5,0,F0F0F0F0,AAAAAAAA}, b lanes={3,1,0F0F0F0F,55555555}.
  - SUB (03) -> {2,FFFFFFFF,E1E1E1E1,55555555}.
  - XOR (06) -> lane2=FFFFFFFF, lane3=FFFFFFFF.
  - AND (04) -> lane2=0, lane3=0.
- MUL latency and truncation:
  - Stimulus: lanes a={3,FFFFFFFF,10000,0}, b={4,2,10000,1234}, opcode=02.
  - Required: result={C,FFFFFFFE,0,0}, done exactly 33 edges after acceptance, busy high throughout.
- Handshake and busy:
  - Stimulus: pulse start with opcode=02, then hold start=1 with opcode=01 and new operands during MUL and DONE.
  - Required: a single MUL result; the ADD is accepted only in the first IDLE cycle afterwards, producing a second done 3 cycles after the first.
- Illegal opcode and reset mid-op:
  - opcode=8'hFF -> done=1 and err=1 on the same cycle, result=0.
  - Start MUL, assert rst at count=10 -> busy=0 next cycle, no done pulse, result=0.
